// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: default widths and the timer FSM state type.
package counter_pkg;

    localparam int COUNTER_DATA_WIDTH     = 8;
    localparam int COUNTER_PRESCALE_WIDTH = 4;
    localparam int COUNTER_STEP           = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage : counter_pkg

// File: rtl/timer_prescaler.sv
// Prescale counter for the countdown timer: emits a one-cycle tick every
// prescale+1 enabled cycles, restarting from zero whenever clr is high.
module timer_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_WIDTH = COUNTER_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] count;

    // A clear suppresses the tick so a reload/stop cycle never also decrements.
    assign tick = en && !clr && (count == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == prescale) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule : timer_prescaler

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with one-shot / auto-reload modes,
// a one-cycle expiry pulse and a sticky interrupt flag.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH     = COUNTER_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = COUNTER_PRESCALE_WIDTH,
    parameter int STEP           = COUNTER_STEP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      preload,
    input  logic [DATA_WIDTH-1:0]     input_data,
    input  logic                      periodic,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      irq_clr,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      busy,
    output logic                      expired,
    output logic                      irq
);

    localparam logic [DATA_WIDTH-1:0] STEP_VAL = DATA_WIDTH'(STEP);

    timer_state_t          state;
    timer_state_t          state_next;
    logic [DATA_WIDTH-1:0] reload;
    logic [DATA_WIDTH-1:0] reload_next;
    logic [DATA_WIDTH-1:0] count_next;
    logic                  expire_now;
    logic                  irq_next;
    logic                  presc_clr;
    logic                  tick;

    // Outside RUN the prescaler is held at zero, so every entry into RUN
    // sees a full prescale period before the first decrement.
    assign presc_clr = (state != RUN) || stop || preload;

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (presc_clr),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control priority: stop, then preload, then start, then the prescaled tick.
    always_comb begin
        state_next  = state;
        count_next  = out_data;
        reload_next = reload;
        expire_now  = 1'b0;

        if (stop) begin
            state_next = IDLE;
        end else if (preload) begin
            reload_next = input_data;
            count_next  = input_data;
            if (state == DONE) begin
                state_next = IDLE;
            end
        end else if (start && (state != RUN)) begin
            if (state == DONE) begin
                count_next = reload;
                state_next = RUN;
            end else if (out_data != '0) begin
                state_next = RUN;
            end else begin
                expire_now = 1'b1;
                if (periodic) begin
                    count_next = reload;
                    state_next = RUN;
                end else begin
                    state_next = DONE;
                end
            end
        end else if (tick) begin
            // Compare before subtracting so the count saturates at zero.
            if (out_data > STEP_VAL) begin
                count_next = out_data - STEP_VAL;
            end else begin
                expire_now = 1'b1;
                if (periodic) begin
                    count_next = reload;
                end else begin
                    count_next = '0;
                    state_next = DONE;
                end
            end
        end

        if (expire_now) begin
            irq_next = 1'b1;
        end else if (irq_clr) begin
            irq_next = 1'b0;
        end else begin
            irq_next = irq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            reload   <= '0;
            expired  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            out_data <= count_next;
            reload   <= reload_next;
            expired  <= expire_now;
            irq      <= irq_next;
        end
    end

    assign busy = (state == RUN);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus randomized
// runs on STEP=1 and STEP=3 instances checked against closed-form expectations.
module tb_countdown_timer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       start;
    logic       stop;
    logic       preload;
    logic [7:0] input_data;
    logic       periodic;
    logic [3:0] prescale;
    logic       irq_clr;

    logic [7:0] out1, out3;
    logic       busy1, busy3, exp1, exp3, irq1, irq3;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(4), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
        .preload(preload), .input_data(input_data), .periodic(periodic),
        .prescale(prescale), .irq_clr(irq_clr),
        .out_data(out1), .busy(busy1), .expired(exp1), .irq(irq1)
    );

    countdown_timer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(4), .STEP(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
        .preload(preload), .input_data(input_data), .periodic(periodic),
        .prescale(prescale), .irq_clr(irq_clr),
        .out_data(out3), .busy(busy3), .expired(exp3), .irq(irq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; preload = 0; irq_clr = 0; en = 1;
    endtask

    // Closed-form expectation after k enabled RUN cycles since start.
    task automatic model_expect(input int n, input int stp, input int p, input int k,
                                input bit per, input bit tick_now,
                                output int cnt, output bit xp, output bit bsy);
        int t, tt;
        t  = k / (p + 1);
        tt = (n + stp - 1) / stp;
        if (tt < 1) tt = 1;
        if (per) begin
            cnt = n - (t % tt) * stp;
            xp  = tick_now && (t % tt == 0);
            bsy = 1;
        end else if (t < tt) begin
            cnt = n - t * stp;
            xp  = 0;
            bsy = 1;
        end else begin
            cnt = 0;
            xp  = tick_now && (t == tt);
            bsy = 0;
        end
    endtask

    task automatic load_and_start(input int n, input int p, input bit per);
        idle_inputs();
        stop = 1; irq_clr = 1;
        step_clk();
        idle_inputs();
        preload = 1; input_data = 8'(n); prescale = 4'(p); periodic = per;
        step_clk();
        idle_inputs();
        start = 1;
        step_clk();
        idle_inputs();
    endtask

    task automatic test_reset();
        checks++;
        if (out1 !== 8'd0) begin errors++; $display("[TB] FAIL reset_out: got %0d want 0", out1); end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy1); end
        checks++;
        if (exp1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_expired: got %b want 0", exp1); end
        checks++;
        if (irq1 !== 1'b0 || irq3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b/%b want 0/0", irq1, irq3); end
    endtask

    task automatic test_oneshot();
        load_and_start(5, 0, 0);
        checks++;
        if (out1 !== 8'd5 || busy1 !== 1'b1) begin
            errors++; $display("[TB] FAIL oneshot_start: out=%0d busy=%b want 5/1", out1, busy1);
        end
        for (int i = 4; i >= 0; i--) begin
            step_clk();
            checks++;
            if (out1 !== 8'(i) || exp1 !== (i == 0)) begin
                errors++; $display("[TB] FAIL oneshot_count: out=%0d exp=%b want %0d/%b", out1, exp1, i, (i == 0));
            end
        end
        checks++;
        if (busy1 !== 1'b0 || irq1 !== 1'b1) begin
            errors++; $display("[TB] FAIL oneshot_done: busy=%b irq=%b want 0/1", busy1, irq1);
        end
        step_clk();
        checks++;
        if (exp1 !== 1'b0 || out1 !== 8'd0) begin
            errors++; $display("[TB] FAIL oneshot_pulse_width: exp=%b out=%0d want 0/0", exp1, out1);
        end
    endtask

    task automatic test_periodic();
        int cyc;
        load_and_start(3, 1, 1);
        for (int w = 0; w < 3; w++) begin
            cyc = 0;
            do begin
                en = (w == 2) ? !(cyc >= 1 && cyc < 5) : 1'b1;
                step_clk();
                cyc++;
            end while (!exp1 && cyc < 30);
            checks++;
            if (cyc !== ((w == 2) ? 10 : 6) || out1 !== 8'd3 || busy1 !== 1'b1) begin
                errors++; $display("[TB] FAIL periodic_interval%0d: cycles=%0d out=%0d busy=%b want %0d/3/1",
                                   w, cyc, out1, busy1, (w == 2) ? 10 : 6);
            end
        end
        idle_inputs();
    endtask

    task automatic test_step3();
        int want[3] = '{4, 1, 0};
        load_and_start(7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step_clk();
            checks++;
            if (out3 !== 8'(want[i]) || exp3 !== (i == 2)) begin
                errors++; $display("[TB] FAIL step3_count: out=%0d exp=%b want %0d/%b", out3, exp3, want[i], (i == 2));
            end
        end
        checks++;
        if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL step3_done: busy=%b want 0", busy3); end
    endtask

    task automatic test_priority();
        load_and_start(10, 0, 0);
        step_clk();
        step_clk();
        stop = 1; preload = 1; input_data = 8'd20;
        step_clk();
        checks++;
        if (out1 !== 8'd8 || busy1 !== 1'b0) begin
            errors++; $display("[TB] FAIL prio_stop_preload: out=%0d busy=%b want 8/0", out1, busy1);
        end
        stop = 0; preload = 1; start = 1;
        step_clk();
        checks++;
        if (out1 !== 8'd20 || busy1 !== 1'b0) begin
            errors++; $display("[TB] FAIL prio_preload_start: out=%0d busy=%b want 20/0", out1, busy1);
        end
        preload = 0; start = 1;
        step_clk();
        checks++;
        if (out1 !== 8'd20 || busy1 !== 1'b1) begin
            errors++; $display("[TB] FAIL prio_start: out=%0d busy=%b want 20/1", out1, busy1);
        end
        idle_inputs();
    endtask

    task automatic test_irq();
        load_and_start(5, 0, 0);
        repeat (4) step_clk();
        irq_clr = 1;
        step_clk();
        checks++;
        if (exp1 !== 1'b1 || irq1 !== 1'b1 || out1 !== 8'd0) begin
            errors++; $display("[TB] FAIL irq_set_wins: exp=%b irq=%b out=%0d want 1/1/0", exp1, irq1, out1);
        end
        step_clk();
        checks++;
        if (irq1 !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear: irq=%b want 0", irq1); end
        irq_clr = 0; start = 1;
        step_clk();
        checks++;
        if (busy1 !== 1'b1 || out1 !== 8'd5) begin
            errors++; $display("[TB] FAIL irq_restart: busy=%b out=%0d want 1/5", busy1, out1);
        end
        start = 0;
        step_clk();
        checks++;
        if (out1 !== 8'd4) begin errors++; $display("[TB] FAIL irq_rerun: out=%0d want 4", out1); end
        load_and_start(0, 0, 0);
        checks++;
        if (exp1 !== 1'b1 || irq1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_start: exp=%b irq=%b busy=%b want 1/1/0", exp1, irq1, busy1);
        end
        step_clk();
        checks++;
        if (exp1 !== 1'b0) begin errors++; $display("[TB] FAIL zero_start_pulse: exp=%b want 0", exp1); end
    endtask

    task automatic test_reset_midrun();
        load_and_start(10, 0, 0);
        repeat (3) step_clk();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (out1 !== 8'd0 || busy1 !== 1'b0 || irq1 !== 1'b0 || exp1 !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_midrun: out=%0d busy=%b irq=%b exp=%b want 0/0/0/0", out1, busy1, irq1, exp1);
        end
        step_clk();
        rst_n = 1;
        step_clk();
        checks++;
        if (exp1 !== 1'b0 || busy1 !== 1'b0 || out1 !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_after: exp=%b busy=%b out=%0d want 0/0/0", exp1, busy1, out1);
        end
    endtask

    task automatic test_random(input bit per, input int iters);
        int n, p, k1, k3, c1, c3, lim;
        bit b1, b3, x1, x3, i1, i3, en_now, t1, t3;
        for (int it = 0; it < iters; it++) begin
            n = $urandom_range(1, 40);
            p = $urandom_range(0, 3);
            load_and_start(n, p, per);
            checks++;
            if (out1 !== 8'(n) || out3 !== 8'(n) || busy1 !== 1'b1 || busy3 !== 1'b1) begin
                errors++; $display("[TB] FAIL rand_start: out=%0d/%0d busy=%b/%b want %0d/1", out1, out3, busy1, busy3, n);
            end
            k1 = 0; k3 = 0; b1 = 1; b3 = 1; i1 = 0; i3 = 0;
            lim = per ? 60 : 400;
            for (int c = 0; c < lim && (b1 || b3); c++) begin
                en_now = ($urandom_range(0, 3) != 0);
                en = en_now;
                step_clk();
                if (b1 && en_now) k1++;
                if (b3 && en_now) k3++;
                t1 = b1 && en_now && (k1 % (p + 1) == 0);
                t3 = b3 && en_now && (k3 % (p + 1) == 0);
                model_expect(n, 1, p, k1, per, t1, c1, x1, b1);
                model_expect(n, 3, p, k3, per, t3, c3, x3, b3);
                i1 = i1 | x1;
                i3 = i3 | x3;
                checks++;
                if (out1 !== 8'(c1) || exp1 !== x1 || busy1 !== b1 || irq1 !== i1) begin
                    errors++; $display("[TB] FAIL rand_step1: out=%0d exp=%b busy=%b irq=%b want %0d/%b/%b/%b",
                                       out1, exp1, busy1, irq1, c1, x1, b1, i1);
                end
                checks++;
                if (out3 !== 8'(c3) || exp3 !== x3 || busy3 !== b3 || irq3 !== i3) begin
                    errors++; $display("[TB] FAIL rand_step3: out=%0d exp=%b busy=%b irq=%b want %0d/%b/%b/%b",
                                       out3, exp3, busy3, irq3, c3, x3, b3, i3);
                end
            end
            if (!per && (b1 || b3)) begin
                errors++; $display("[TB] FAIL rand_timeout: busy model %b/%b after %0d cycles", b1, b3, lim);
            end
            idle_inputs();
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        input_data = 0; periodic = 0; prescale = 0;
        repeat (2) step_clk();
        rst_n = 1;
        step_clk();
        test_reset();
        test_oneshot();
        test_periodic();
        test_step3();
        test_priority();
        test_irq();
        test_reset_midrun();
        test_random(1'b0, 8);
        test_random(1'b1, 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_countdown_timer
